uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Shares one UART transmitter among NUM_REQ requesters (host port, BIST, loopback responder, etc.) using round-robin arbitration. Latches the winner's byte and drives Tx_Data/Transmit_Start using the transmitter's handshake: Start is held until Tx_Busy rises, then the scheduler waits for Tx_Busy to fall. Gates new grants on CTS and reports completion or start timeout back to the owning requester. Sits between the requester logic and the UART transmitter inside the UART top.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_BITS, 8, transmit word width; matches the UART DATA_BITS
START_TIMEOUT, 16, Clk cycles Transmit_Start may stay high without Tx_Busy rising before abort (>=2)
IDX_W, $clog2(NUM_REQ), owner index width (localparam, min 1)

Ports:
Clk  in  1  baud/system clock, all logic on posedge
Rst_n  in  1  asynchronous active-low reset
Req  in  NUM_REQ  per-requester transmit request, level
Req_Data  in  NUM_REQ*DATA_BITS  packed bytes; requester i uses [i*DATA_BITS +: DATA_BITS]
Ack  out  NUM_REQ  one-hot 1-cycle pulse: byte latched, requester may drop Req/change data
Done  out  NUM_REQ  one-hot 1-cycle pulse: owner's byte fully transmitted
Timeout_Err  out  1  1-cycle pulse: Tx_Busy never rose; Owner still valid that cycle
CTS  in  1  flow control; 1 = transmission allowed
Tx_Busy  in  1  from transmitter
Tx_Data  out  DATA_BITS  to transmitter, stable from LOAD through BUSY
Transmit_Start  out  1  to transmitter
Owner  out  IDX_W  index of current or last granted requester
Active  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Rst_n=0) sets state IDLE, Ack=0, Done=0, Timeout_Err=0, Transmit_Start=0, Tx_Data=0, Owner=0, Active=0, and RR pointer=0. Reset mid-transfer drops Transmit_Start immediately and generates no Done.
- All outputs are registered.
- States: IDLE, LOAD, START, BUSY, DONE.
- IDLE: a grant occurs when |Req, CTS=1 and Tx_Busy=0 are all true.
  - Winner is the first asserted Req at or after the pointer, wrapping from NUM_REQ-1 to 0.
  - Next cycle: Tx_Data<=Req_Data[winner], Owner<=winner, Ack[winner]=1 for one cycle, state LOAD.
- LOAD: one cycle for data setup. Next cycle Transmit_Start=1 and the timeout counter clears; state START.
- START: Transmit_Start is held at 1 and the counter increments each cycle.
  - If Tx_Busy=1: Transmit_Start<=0 and go to BUSY.
  - Else if counter==START_TIMEOUT-1: Transmit_Start<=0, Timeout_Err pulse, pointer<=Owner+1 (mod NUM_REQ), go to IDLE. No Done is issued.
  - Tx_Busy takes priority when both occur in the same cycle.
- BUSY: wait until Tx_Busy=0, then go to DONE.
- DONE: Done[Owner] pulses for one cycle, pointer<=Owner+1 (mod NUM_REQ), go to IDLE.
- Back-to-back: at least one IDLE cycle separates transfers, so the minimum gap after a Done pulse is 1 cycle.
- CTS is sampled only in IDLE. CTS dropping after a grant does not abort the current byte.
- Req changing after Ack is ignored until the next arbitration.
- A requester that holds Req continuously is re-granted only after all other pending requesters have been served.
- Tx_Busy=1 in IDLE (external or BIST use of the transmitter) blocks granting. There is no error in this case.
- Single requester: it is granted repeatedly, one transfer every 4+busy cycles.

Decomposition:
- Package uart_pkg holds the sched_state_t enum (IDLE, LOAD, START, BUSY, DONE) and the DATA_BITS default, shared with the UART top.
- One sub-module, uart_rr_arbiter, is combinational. Its inputs are Req and the pointer; its outputs are the one-hot grant and the encoded index. It is reusable for the RX-side consumers.
- The scheduler FSM, counter and data mux stay in uart_tx_scheduler.

Test Plan:
- Reset mid-BUSY: Rst_n=0 → Transmit_Start, Active and Done are 0 asynchronously; after release, state is IDLE and Owner=0.
- Single request: Req=4'b0010, Req_Data[1]=8'hA5, CTS=1; model Tx_Busy rising 2 cycles after Start and lasting 12 cycles.
  - Ack[1] one cycle after Req.
  - Tx_Data=8'hA5.
  - Start high exactly until Tx_Busy rises.
  - Done[1] one cycle after Tx_Busy falls.
- Round-robin fairness: Req=4'b1111 held; data 8'h10/8'h11/8'h12/8'h13 → grant order 0,1,2,3,0; each Done is one-hot and matches Owner.
- Wrap and skip: pointer=3, Req=4'b0101 → requester 0 is granted, then 2.
- CTS gating: CTS=0 with Req=4'b0001 for 20 cycles → no Ack and Start stays 0. Raise CTS → Ack[0] on the next cycle.
- Timeout: Tx_Busy tied to 0, Req=4'b0100 → Start is high for 16 cycles, then Timeout_Err pulses with Owner=2 and no Done; the next grant goes to requester 3 if requesting, else wraps.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit scheduler state encoding and default word width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    DONE
  } sched_state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after Ptr, wrapping.
module uart_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [IDX_W-1:0]   Ptr,
  output logic [NUM_REQ-1:0] Grant,
  output logic [IDX_W-1:0]   Grant_Idx,
  output logic               Grant_Vld
);

  int k;

  always_comb begin
    Grant     = '0;
    Grant_Idx = '0;
    Grant_Vld = 1'b0;
    k         = 0;
    // Scan in priority order starting at the pointer; first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(Ptr) + i) % NUM_REQ;
      if (!Grant_Vld && Req[k]) begin
        Grant_Vld = 1'b1;
        Grant[k]  = 1'b1;
        Grant_Idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin arbitration,
// Start/Busy handshake, CTS gating and start timeout reporting.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_BITS     = UART_DATA_BITS,
  parameter  int START_TIMEOUT = 16,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Ack,
  output logic [NUM_REQ-1:0]             Done,
  output logic                           Timeout_Err,
  input  logic                           CTS,
  input  logic                           Tx_Busy,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  output logic [IDX_W-1:0]               Owner,
  output logic                           Active
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  sched_state_t           state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     ack_d, done_d;
  logic                   tmo_d, start_d, active_d;
  logic [DATA_BITS-1:0]   data_d;
  logic [IDX_W-1:0]       owner_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;
  logic                   grant_ok;
  logic                   start_expired;
  logic [IDX_W-1:0]       owner_inc;
  logic [DATA_BITS-1:0]   req_bytes [NUM_REQ];

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .Req       (Req),
    .Ptr       (ptr_q),
    .Grant     (grant),
    .Grant_Idx (win_idx),
    .Grant_Vld (win_vld)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = Req_Data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // New grants need the transmitter idle and the far end ready; CTS is ignored afterwards.
  assign grant_ok      = win_vld && CTS && !Tx_Busy;
  assign start_expired = (cnt_q == CNT_W'(START_TIMEOUT - 1));
  assign owner_inc     = (Owner == IDX_W'(NUM_REQ - 1)) ? '0 : Owner + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      Ack            <= '0;
      Done           <= '0;
      Timeout_Err    <= 1'b0;
      Transmit_Start <= 1'b0;
      Tx_Data        <= '0;
      Owner          <= '0;
      Active         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      Ack            <= ack_d;
      Done           <= done_d;
      Timeout_Err    <= tmo_d;
      Transmit_Start <= start_d;
      Tx_Data        <= data_d;
      Owner          <= owner_d;
      Active         <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ok) state_d = LOAD;
      LOAD:    state_d = START;
      START: begin
        // Busy wins over an expiry landing in the same cycle.
        if (Tx_Busy)            state_d = BUSY;
        else if (start_expired) state_d = IDLE;
      end
      BUSY:    if (!Tx_Busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d    = '0;
    done_d   = '0;
    tmo_d    = 1'b0;
    start_d  = Transmit_Start;
    data_d   = Tx_Data;
    owner_d  = Owner;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          ack_d   = grant;
          data_d  = req_bytes[win_idx];
          owner_d = win_idx;
        end
      end
      LOAD: begin
        start_d = 1'b1;
        cnt_d   = '0;
      end
      START: begin
        if (Tx_Busy) begin
          start_d = 1'b0;
        end else if (start_expired) begin
          start_d = 1'b0;
          tmo_d   = 1'b1;
          ptr_d   = owner_inc;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!Tx_Busy) done_d = NUM_REQ'(1) << Owner;
      end
      DONE: begin
        ptr_d = owner_inc;
      end
      default: begin
        start_d = 1'b0;
      end
    endcase
    active_d = (state_d != IDLE);
  end

endmodule
